// File: rtl/ift_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ift_trace_pkg
//  Description : Shared types and trace-word layout helpers for the IFT trace
//                capture block. A trace word is {timestamp, taint, value} with
//                the timestamp in the most significant bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package ift_trace_pkg;

    // Capture session state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_t;

    // Bit offset of the observed value field (least significant).
    function automatic int data_lsb();
        return 0;
    endfunction

    // Bit offset of the taint field, directly above the value.
    function automatic int taint_lsb(input int data_w);
        return data_w;
    endfunction

    // Bit offset of the timestamp field, directly above the taint.
    function automatic int ts_lsb(input int data_w, input int taint_w);
        return data_w + taint_w;
    endfunction

    // Total trace word width.
    function automatic int entry_width(input int ts_w, input int taint_w, input int data_w);
        return ts_w + taint_w + data_w;
    endfunction

endpackage : ift_trace_pkg
`default_nettype wire

// File: rtl/ift_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ift_trace_fifo
//  Description : Trace-word storage with read/write pointers and occupancy.
//                A write into a full buffer is ignored; fullness is judged on
//                the occupancy before any same-cycle pop. clear empties the
//                buffer synchronously and overrides same-cycle write/pop.
//  Ports       : clk, rst_n     - clock, asynchronous active-low reset
//                clear          - empty the buffer
//                wr_en, wr_data - push one word (ignored when full)
//                rd_pop         - pop head word (ignored when empty)
//                rd_valid       - buffer not empty
//                rd_data        - head word (zero when empty)
//                count          - words held
//                full           - count == DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module ift_trace_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_pop,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth_cnt = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;

    logic w_empty;
    logic w_full;
    logic w_do_wr;
    logic w_do_pop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_depth_cnt);
    assign w_do_wr  = wr_en && !w_full;
    assign w_do_pop = rd_pop && !w_empty;

    // Pointers and occupancy. DEPTH is a power of two so the pointers wrap
    // naturally on overflow of their bit width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array carries no reset; stale contents are masked by rd_data.
    always_ff @(posedge clk) begin
        if (w_do_wr && !clear) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_valid = !w_empty;
    assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count    = r_count;
    assign full     = w_full;

endmodule : ift_trace_fifo
`default_nettype wire

// File: rtl/ift_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : ift_trace_capture
//  Description : Observation-side capture for IFT flip-flop tests. Samples the
//                observed value q and its taint vector q_t, packs them with a
//                cycle timestamp into trace words, buffers them, and drains
//                them through a valid/ready read port.
//  Ports       : clk, rst_n       - clock, asynchronous active-low reset
//                arm, stop        - start / end a capture session (pulses)
//                trig_mode        - 0: trigger at once, 1: on first q_t != 0
//                change_only      - 1: write only when {q,q_t} changed
//                q, q_t           - observed value and taint
//                rd_ready         - consumer accepts head entry
//                rd_valid/rd_data - head entry {ts, q_t, q}
//                count            - entries held
//                busy, done       - session state flags
//                overflow         - sticky: a write was dropped (buffer full)
//                taint_seen       - sticky: a written entry had q_t != 0
//  Revision    : 1.0 - initial release
// ============================================================================
module ift_trace_capture
    import ift_trace_pkg::*;
#(
    parameter  int DATA_W  = 2,
    parameter  int TAINT_W = 32,
    parameter  int DEPTH   = 8,
    parameter  int TS_W    = 16,
    localparam int ENTRY_W = TS_W + TAINT_W + DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   trig_mode,
    input  logic                   change_only,
    input  logic [DATA_W-1:0]      q,
    input  logic [TAINT_W-1:0]     q_t,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [ENTRY_W-1:0]     rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   taint_seen
);

    localparam int c_ts_lsb    = ts_lsb(DATA_W, TAINT_W);
    localparam int c_taint_lsb = taint_lsb(DATA_W);
    localparam int c_data_lsb  = data_lsb();
    localparam int c_entry_w   = entry_width(TS_W, TAINT_W, DATA_W);
    localparam int c_sample_w  = DATA_W + TAINT_W;

    trace_state_t            r_state;
    trace_state_t            w_state_next;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_trig_mode;
    logic                    r_change_only;
    logic [TS_W-1:0]         r_ts;
    logic [c_sample_w-1:0]   r_last;
    logic                    r_overflow;
    logic                    r_taint_seen;

    logic                    w_in_armed;
    logic                    w_in_capture;
    logic                    w_trigger;
    logic                    w_changed;
    logic                    w_wr_req;
    logic                    w_wr_en;
    logic                    w_drop;
    logic                    w_full;
    logic                    w_rd_valid;
    logic [c_entry_w-1:0]    w_wr_data;

    assign w_in_armed   = (r_state == ST_ARMED);
    assign w_in_capture = (r_state == ST_CAPTURE);
    assign w_trigger    = w_in_armed && (!r_trig_mode || (|q_t));
    assign w_changed    = ({q, q_t} != r_last);

    // A write is wanted on the trigger sample and on qualifying capture
    // samples. arm restarts the session and stop's sample is discarded, so
    // neither cycle produces a write.
    assign w_wr_req = !arm && !stop &&
                      (w_trigger || (w_in_capture && (!r_change_only || w_changed)));
    assign w_wr_en  = w_wr_req && !w_full;
    assign w_drop   = w_wr_req && w_full;

    always_comb begin
        w_wr_data = '0;
        w_wr_data[c_ts_lsb    +: TS_W]    = r_ts;
        w_wr_data[c_taint_lsb +: TAINT_W] = q_t;
        w_wr_data[c_data_lsb  +: DATA_W]  = q;
    end

    always_comb begin
        w_state_next = r_state;
        if (arm) begin
            w_state_next = ST_ARMED;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_next = ST_IDLE;
                ST_ARMED: begin
                    if (stop || w_drop) begin
                        w_state_next = ST_DONE;
                    end else if (w_trigger) begin
                        w_state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (stop || w_drop) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_DONE:    w_state_next = ST_DONE;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    // State register with registered status flags derived from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_ARMED) || (w_state_next == ST_CAPTURE);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // Session configuration, timestamp, change reference and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_mode   <= 1'b0;
            r_change_only <= 1'b0;
            r_ts          <= '0;
            r_last        <= '0;
            r_overflow    <= 1'b0;
            r_taint_seen  <= 1'b0;
        end else if (arm) begin
            r_trig_mode   <= trig_mode;
            r_change_only <= change_only;
            r_ts          <= '0;
            r_overflow    <= 1'b0;
            r_taint_seen  <= 1'b0;
        end else begin
            // Counts every busy cycle, saturating; holds in IDLE/DONE.
            if (r_busy && (r_ts != {TS_W{1'b1}})) begin
                r_ts <= r_ts + 1'b1;
            end
            if (w_wr_en) begin
                r_last <= {q, q_t};
                if (|q_t) begin
                    r_taint_seen <= 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    ift_trace_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (arm),
        .wr_en    (w_wr_en),
        .wr_data  (w_wr_data),
        .rd_pop   (rd_ready),
        .rd_valid (w_rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (w_full)
    );

    assign rd_valid   = w_rd_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign taint_seen = r_taint_seen;

endmodule : ift_trace_capture
`default_nettype wire

// File: tb/tb_ift_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ift_trace_capture
//  Description : Directed, self-checking bench for ift_trace_capture with the
//                default parameters (DATA_W=2, TAINT_W=32, DEPTH=8, TS_W=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ift_trace_capture;

    localparam int ENTRY_W = 50;
    localparam int TS_LSB  = 34;

    logic               clk;
    logic               rst_n;
    logic               arm;
    logic               stop;
    logic               trig_mode;
    logic               change_only;
    logic [1:0]         q;
    logic [31:0]        q_t;
    logic               rd_ready;
    logic               rd_valid;
    logic [ENTRY_W-1:0] rd_data;
    logic [3:0]         count;
    logic               busy;
    logic               done;
    logic               overflow;
    logic               taint_seen;

    int n_checks;
    int n_errors;

    ift_trace_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm         (arm),
        .stop        (stop),
        .trig_mode   (trig_mode),
        .change_only (change_only),
        .q           (q),
        .q_t         (q_t),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .taint_seen  (taint_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arm;
        logic        stop;
        logic        trig;
        logic        chg;
        logic        rd_ready;
        logic [1:0]  q;
        logic [31:0] qt;
        logic [3:0]  e_count;
        logic        e_busy;
        logic        e_done;
        logic        e_valid;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] ent(input logic [15:0] ts, input logic [31:0] t,
                                               input logic [1:0] d);
        return {ts, t, d};
    endfunction

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm(input logic tm, input logic co);
        trig_mode   = tm;
        change_only = co;
        arm         = 1'b1;
        step();
        arm         = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_ts;
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        arm         = 1'b0;
        stop        = 1'b0;
        trig_mode   = 1'b0;
        change_only = 1'b0;
        q           = '0;
        q_t         = '0;
        rd_ready    = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_rd_valid",   64'(rd_valid),   64'd0);
        check("rst_rd_data",    64'(rd_data),    64'd0);
        check("rst_count",      64'(count),      64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_done",       64'(done),       64'd0);
        check("rst_overflow",   64'(overflow),   64'd0);
        check("rst_taint_seen", 64'(taint_seen), 64'd0);
        rst_n = 1'b1;
        step();

        // ---------------- test 1: change-only capture (table) ----------------
        //             arm   stop  trig  chg   rdy   q      qt    cnt  busy  done  valid
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 4'd1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 32'd0, 4'd2, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 32'd0, 4'd2, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'd0, 4'd3, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'd0, 4'd3, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            arm         = tbl[i].arm;
            stop        = tbl[i].stop;
            trig_mode   = tbl[i].trig;
            change_only = tbl[i].chg;
            rd_ready    = tbl[i].rd_ready;
            q           = tbl[i].q;
            q_t         = tbl[i].qt;
            step();
            check($sformatf("t1_count[%0d]", i), 64'(count),    64'(tbl[i].e_count));
            check($sformatf("t1_busy[%0d]", i),  64'(busy),     64'(tbl[i].e_busy));
            check($sformatf("t1_done[%0d]", i),  64'(done),     64'(tbl[i].e_done));
            check($sformatf("t1_valid[%0d]", i), 64'(rd_valid), 64'(tbl[i].e_valid));
        end
        arm  = 1'b0;
        stop = 1'b0;
        check("t1_taint_seen", 64'(taint_seen), 64'd0);
        rd_ready = 1'b1;
        check("t1_entry0", 64'(rd_data), 64'(ent(16'd0, 32'd0, 2'b00)));
        step();
        check("t1_entry1", 64'(rd_data), 64'(ent(16'd1, 32'd0, 2'b01)));
        step();
        check("t1_entry2", 64'(rd_data), 64'(ent(16'd3, 32'd0, 2'b11)));
        step();
        check("t1_drained_count", 64'(count),    64'd0);
        check("t1_drained_valid", 64'(rd_valid), 64'd0);
        rd_ready = 1'b0;

        // ---------------- test 2: taint trigger ----------------
        q   = 2'b01;
        q_t = 32'd0;
        pulse_arm(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            q = 2'(i);
            step();
        end
        check("t2_no_trigger_count", 64'(count), 64'd0);
        check("t2_armed_busy",       64'(busy),  64'd1);
        q   = 2'b10;
        q_t = 32'h1;
        step();
        check("t2_count",      64'(count),      64'd1);
        check("t2_entry",      64'(rd_data),    64'(ent(16'd5, 32'h1, 2'b10)));
        check("t2_busy",       64'(busy),       64'd1);
        check("t2_taint_seen", 64'(taint_seen), 64'd1);
        q_t  = 32'd0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t2_done", 64'(done), 64'd1);

        // ---------------- test 3: overflow without reads ----------------
        pulse_arm(1'b0, 1'b0);
        check("t3_arm_clears_taint", 64'(taint_seen), 64'd0);
        check("t3_arm_clears_count", 64'(count),      64'd0);
        for (int i = 0; i < 8; i++) begin
            q = 2'(i);
            step();
        end
        check("t3_full_count", 64'(count),    64'd8);
        check("t3_full_busy",  64'(busy),     64'd1);
        check("t3_full_ovf",   64'(overflow), 64'd0);
        q = 2'b11;
        step();
        check("t3_count",    64'(count),    64'd8);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_done",     64'(done),     64'd1);
        check("t3_busy",     64'(busy),     64'd0);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_drain[%0d]", i), 64'(rd_data),
                  64'(ent(16'(i), 32'd0, 2'(i))));
            step();
        end
        check("t3_drained_count", 64'(count), 64'd0);

        // ---------------- test 4: streaming with continuous reads ----------------
        rd_ready = 1'b1;
        pulse_arm(1'b0, 1'b0);
        exp_ts = 16'd0;
        for (int i = 0; i < 21; i++) begin
            q    = 2'(i);
            stop = (i == 20);
            step();
            if (rd_valid) begin
                check($sformatf("t4_ts[%0d]", i), 64'(rd_data[TS_LSB +: 16]), 64'(exp_ts));
                exp_ts = exp_ts + 16'd1;
            end
        end
        stop = 1'b0;
        check("t4_entries_seen", 64'(exp_ts),   64'd20);
        check("t4_count",        64'(count),    64'd0);
        check("t4_overflow",     64'(overflow), 64'd0);
        check("t4_done",         64'(done),     64'd1);
        rd_ready = 1'b0;

        // ---------------- test 5: full with same-cycle pop ----------------
        pulse_arm(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            q = 2'(i);
            step();
        end
        check("t5_pre_count", 64'(count), 64'd8);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("t5_count",    64'(count),                   64'd7);
        check("t5_overflow", 64'(overflow),                64'd1);
        check("t5_done",     64'(done),                    64'd1);
        check("t5_head_ts",  64'(rd_data[TS_LSB +: 16]),   64'd1);

        // ---------------- test 6: asynchronous reset mid-capture ----------------
        pulse_arm(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            q = 2'(i);
            step();
        end
        check("t6_pre_count", 64'(count), 64'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(rd_valid), 64'd0);
        check("t6_rst_count", 64'(count),    64'd0);
        check("t6_rst_busy",  64'(busy),     64'd0);
        check("t6_rst_data",  64'(rd_data),  64'd0);
        #2;
        rst_n = 1'b1;
        step();
        check("t6_idle_busy", 64'(busy), 64'd0);
        check("t6_idle_done", 64'(done), 64'd0);
        q = 2'b10;
        pulse_arm(1'b0, 1'b0);
        step();
        check("t6_restart_count", 64'(count),   64'd1);
        check("t6_restart_entry", 64'(rd_data), 64'(ent(16'd0, 32'd0, 2'b10)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ift_trace_capture
`default_nettype wire

// File: doc/ift_trace_capture.md
Name: ift_trace_capture

Overview:
Synthesizable capture block for the observation side of IFT flip-flop test setups. Stimulus words are unpacked into value and taint inputs on the drive side. This block does the opposite: it samples a DUT output value Q and its taint vector Q_t, then packs them with a cycle timestamp into fixed-width trace words. Words are held in a small FIFO and drained through a valid/ready read port.

Parameters:
DATA_W, 2, width of observed value Q
TAINT_W, 32, width of observed taint Q_t
DEPTH, 8, trace entries (power of two, >=2)
TS_W, 16, timestamp width
ENTRY_W, TS_W+TAINT_W+DATA_W, trace word width (derived, not overridable)

Ports:
CLK  in  1  single clock, rising edge
RST_N  in  1  asynchronous active-low reset
ARM  in  1  pulse: clear buffer and status, start a capture session
STOP  in  1  pulse: end the session (go to DONE)
TRIG_MODE  in  1  0 = trigger immediately; 1 = trigger on first Q_t != 0 (sampled at ARM)
CHANGE_ONLY  in  1  1 = write only when {Q,Q_t} differs from the last written sample; 0 = write every cycle (sampled at ARM)
Q  in  DATA_W  observed value
Q_t  in  TAINT_W  observed taint
RD_READY  in  1  consumer accepts head entry
RD_VALID  out  1  head entry available (COUNT != 0)
RD_DATA  out  ENTRY_W  {timestamp, Q_t, Q}, with timestamp in the MSBs
COUNT  out  $clog2(DEPTH)+1  entries held
BUSY  out  1  state is ARMED or CAPTURE
DONE  out  1  state is DONE
OVERFLOW  out  1  sticky: a write was dropped because the buffer was full
TAINT_SEEN  out  1  sticky: some written entry had Q_t != 0

Behaviour:
- Reset: RST_N low asynchronously forces state IDLE, pointers 0, COUNT 0, timestamp 0, and all outputs 0 (RD_DATA 0). Reset mid-session discards all entries.
- States:
  - IDLE: ARM -> ARMED.
  - ARMED: trigger -> CAPTURE.
  - CAPTURE: STOP or overflow -> DONE.
  - DONE: ARM -> ARMED.
  - STOP in ARMED also goes to DONE. STOP in IDLE or DONE is ignored. ARM in ARMED or CAPTURE restarts the session.
- ARM cycle:
  - Clears the pointers, COUNT, OVERFLOW and TAINT_SEEN.
  - Latches TRIG_MODE and CHANGE_ONLY.
  - Sets the timestamp to 0.
  - ARM wins over STOP when both are asserted in the same cycle.
- Timestamp: 0 in the first ARMED cycle; +1 every cycle while BUSY; saturates at all-ones; frozen in DONE.
- Trigger: in ARMED, when TRIG_MODE=0, or when TRIG_MODE=1 and |Q_t is true.
  - The triggering sample is always written as the first entry.
  - The state moves to CAPTURE on the same edge.
- Write rule in CAPTURE:
  - CHANGE_ONLY=0: write every cycle.
  - CHANGE_ONLY=1: write only when {Q,Q_t} differs from the last written sample.
  - A sample on the STOP cycle is not written.
- Latency: a sample taken at edge n is visible on RD_VALID/RD_DATA after edge n; a write into an empty FIFO is readable in the next cycle.
- Read: pop on RD_VALID && RD_READY. Reads are allowed in every state, including IDLE and DONE. RD_DATA is the head entry and stays stable while RD_VALID && !RD_READY.
- Full boundary: fullness is judged before the same-cycle pop.
  - If a write is required while COUNT==DEPTH, the write is dropped, even if a pop occurs in that cycle.
  - OVERFLOW is set and the state moves to DONE.
- A simultaneous write and pop when not full leaves COUNT unchanged.
- Pointers wrap modulo DEPTH.
- TAINT_SEEN is set on any accepted write with Q_t != 0.

Decomposition:
- Package ift_trace_pkg holds:
  - state enum {IDLE, ARMED, CAPTURE, DONE}
  - entry field offsets/width functions (TS_LSB, TAINT_LSB, DATA_LSB)
- Sub-module ift_trace_fifo: storage, pointers, COUNT, and full/empty logic, with inputs wr_en/wr_data/rd_pop/clear.
- Top level: FSM, timestamp, change detection, and sticky flags.

Test Plan:
1. TRIG_MODE=0, CHANGE_ONLY=1, RD_READY=0; ARM, then Q=00,01,01,11 with Q_t=0 -> COUNT=3; entries {ts0,0,00},{ts1,0,01},{ts3,0,11}; TAINT_SEEN=0.
2. TRIG_MODE=1; Q_t=0 for 5 cycles after ARM, then Q_t=0x1, Q=10 -> first entry ts=5, Q_t=1, Q=10; BUSY=1, TAINT_SEEN=1.
3. CHANGE_ONLY=0, RD_READY=0, 9 capture cycles -> COUNT=8, OVERFLOW=1, DONE=1, BUSY=0; drain yields ts 0..7 in order.
4. CHANGE_ONLY=0, RD_READY=1 held for 20 cycles, then STOP -> no overflow; drained timestamps contiguous 0..19; COUNT=0 after drain.
5. Full with simultaneous pop: COUNT=8, pop and required write in the same cycle -> write dropped, OVERFLOW=1, COUNT=7.
6. RST_N low mid-CAPTURE with 3 entries, asynchronously between edges -> RD_VALID=0, COUNT=0, BUSY=0 immediately; after release, ARM starts cleanly at ts=0.
